// File: rtl/mpe_axi_pkg.sv
// Shared AXI-side constants and types for the memory-pipeline ingress blocks.
package mpe_axi_pkg;

  localparam int LINEBITS = 512;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [2:0] AXI_SIZE_64 = 3'd3;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    REQ,
    RESP
  } wg_state_e;

endpackage

// File: rtl/axi4_wline_gather_if.sv
// AXI4 write channels plus the Frontend line-request port seen by axi4_wline_gather.
interface axi4_wline_gather_if #(
  parameter int IDBITS   = 4,
  parameter int DATABITS = 64,
  parameter int ADDRBITS = 32
);
  import mpe_axi_pkg::*;

  logic                    awvalid;
  logic                    awready;
  logic [IDBITS-1:0]       awid;
  logic [ADDRBITS-1:0]     awaddr;
  logic [7:0]              awlen;
  logic [2:0]              awsize;
  logic [1:0]              awburst;

  logic                    wvalid;
  logic                    wready;
  logic [DATABITS-1:0]     wdata;
  logic [DATABITS/8-1:0]   wstrb;
  logic                    wlast;

  logic                    bvalid;
  logic                    bready;
  logic [IDBITS-1:0]       bid;
  logic [1:0]              bresp;

  logic                    req_valid;
  logic                    req_ready;
  logic [ADDRBITS-1:0]     req_addr;
  logic [IDBITS-1:0]       req_id;
  logic [LINEBITS-1:0]     req_data;

  // The gather block: AXI slave on the write side, request source toward the Frontend.
  modport slave (
    input  awvalid, awid, awaddr, awlen, awsize, awburst,
    output awready,
    input  wvalid, wdata, wstrb, wlast,
    output wready,
    output bvalid, bid, bresp,
    input  bready,
    output req_valid, req_addr, req_id, req_data,
    input  req_ready
  );

  modport master (
    output awvalid, awid, awaddr, awlen, awsize, awburst,
    input  awready,
    output wvalid, wdata, wstrb, wlast,
    input  wready,
    input  bvalid, bid, bresp,
    output bready,
    input  req_valid, req_addr, req_id, req_data,
    output req_ready
  );

endinterface

// File: rtl/axi4_wline_gather.sv
// Collects one 8-beat AXI4 write burst into a 512-bit line request for the Frontend,
// answering B with OKAY after the Frontend takes the line, or SLVERR for malformed bursts.
module axi4_wline_gather
  import mpe_axi_pkg::*;
#(
  parameter int IDBITS   = 4,
  parameter int DATABITS = 64,
  parameter int ADDRBITS = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  axi4_wline_gather_if.slave    bus
);

  localparam int BEATS    = LINEBITS / DATABITS;
  localparam int CNTBITS  = $clog2(BEATS);
  localparam int LINE_OFS = $clog2(LINEBITS / 8);
  localparam logic [CNTBITS-1:0] LAST_BEAT  = CNTBITS'(BEATS - 1);
  localparam logic [7:0]         AWLEN_LINE = 8'(BEATS - 1);

  wg_state_e            r_state;
  wg_state_e            w_state_next;
  logic [CNTBITS-1:0]   r_cnt;
  logic [CNTBITS-1:0]   w_cnt_next;
  logic                 r_err;
  logic                 w_err_next;

  logic [IDBITS-1:0]    r_id;
  logic [ADDRBITS-1:0]  r_addr;
  logic [LINEBITS-1:0]  r_line;
  logic [1:0]           r_bresp;

  logic                 r_awready;
  logic                 r_wready;
  logic                 r_req_valid;
  logic                 r_bvalid;

  logic                 w_aw_fire;
  logic                 w_w_fire;
  logic                 w_req_fire;
  logic                 w_b_fire;
  logic                 w_unused;

  // Handshakes use the registered ready/valid so nothing on the bus is combinational.
  assign w_aw_fire  = bus.awvalid & r_awready;
  assign w_w_fire   = bus.wvalid & r_wready;
  assign w_req_fire = r_req_valid & bus.req_ready;
  assign w_b_fire   = r_bvalid & bus.bready;

  // The line is always filled sequentially, so the burst type carries no information.
  assign w_unused = ^bus.awburst;

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_err_next   = r_err;
    case (r_state)
      IDLE: begin
        if (w_aw_fire) begin
          w_state_next = DATA;
          w_cnt_next   = '0;
          w_err_next   = (bus.awlen != AWLEN_LINE) || (bus.awsize != AXI_SIZE_64) ||
                         (bus.awaddr[LINE_OFS-1:0] != '0);
        end
      end
      DATA: begin
        if (w_w_fire) begin
          w_cnt_next = r_cnt + 1'b1;
          if (!(&bus.wstrb) || (bus.wlast != (r_cnt == LAST_BEAT))) begin
            w_err_next = 1'b1;
          end
          // An early wlast is only an error; the burst always runs to its 8th beat.
          if (r_cnt == LAST_BEAT) begin
            w_state_next = w_err_next ? RESP : REQ;
          end
        end
      end
      REQ: begin
        if (w_req_fire) begin
          w_state_next = RESP;
        end
      end
      RESP: begin
        if (w_b_fire) begin
          w_state_next = IDLE;
          w_err_next   = 1'b0;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_err       <= 1'b0;
      r_id        <= '0;
      r_addr      <= '0;
      r_line      <= '0;
      r_bresp     <= RESP_OKAY;
      r_awready   <= 1'b0;
      r_wready    <= 1'b0;
      r_req_valid <= 1'b0;
      r_bvalid    <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_cnt       <= w_cnt_next;
      r_err       <= w_err_next;
      r_awready   <= (w_state_next == IDLE);
      r_wready    <= (w_state_next == DATA);
      r_req_valid <= (w_state_next == REQ);
      r_bvalid    <= (w_state_next == RESP);
      r_bresp     <= ((w_state_next == RESP) && w_err_next) ? RESP_SLVERR : RESP_OKAY;
      if (w_aw_fire) begin
        r_id   <= bus.awid;
        r_addr <= {bus.awaddr[ADDRBITS-1:LINE_OFS], {LINE_OFS{1'b0}}};
      end
      if (w_w_fire) begin
        r_line[int'(r_cnt) * DATABITS +: DATABITS] <= bus.wdata;
      end
    end
  end

  assign bus.awready   = r_awready;
  assign bus.wready    = r_wready;
  assign bus.bvalid    = r_bvalid;
  assign bus.bid       = r_id;
  assign bus.bresp     = r_bresp;
  assign bus.req_valid = r_req_valid;
  assign bus.req_addr  = r_addr;
  assign bus.req_id    = r_id;
  assign bus.req_data  = r_line;

endmodule

// File: tb/tb_axi4_wline_gather.sv
// Directed bench for axi4_wline_gather: one task per scenario with inline checks.
module tb_axi4_wline_gather;
  import mpe_axi_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  axi4_wline_gather_if bus ();

  axi4_wline_gather dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int vectors     = 0;
  int miscompares = 0;
  int req_seen    = 0;

  always @(posedge clock) begin
    if (bus.req_valid) req_seen <= req_seen + 1;
  end

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs;
    bus.awvalid   = 1'b0;
    bus.awid      = '0;
    bus.awaddr    = '0;
    bus.awlen     = '0;
    bus.awsize    = '0;
    bus.awburst   = 2'b01;
    bus.wvalid    = 1'b0;
    bus.wdata     = '0;
    bus.wstrb     = '0;
    bus.wlast     = 1'b0;
    bus.bready    = 1'b0;
    bus.req_ready = 1'b0;
  endtask

  task automatic send_aw(input logic [3:0] id, input logic [31:0] addr,
                         input logic [7:0] len, input logic [2:0] size);
    int n;
    bus.awvalid = 1'b1;
    bus.awid    = id;
    bus.awaddr  = addr;
    bus.awlen   = len;
    bus.awsize  = size;
    n = 0;
    while (!bus.awready && n < 50) begin
      tick();
      n++;
    end
    if (!bus.awready) begin
      vectors++;
      miscompares++;
      $display("FAIL aw_timeout awready=%0b required=1", bus.awready);
    end
    tick();
    bus.awvalid = 1'b0;
  endtask

  task automatic send_beats(input logic [63:0] base, input int nbeats, input int last_at,
                            input int bad_strb_at, input bit bubbles, output int accepted);
    int n;
    accepted = 0;
    for (int k = 0; k < nbeats; k++) begin
      bus.wvalid = 1'b1;
      bus.wdata  = base + 64'(k);
      bus.wstrb  = (k == bad_strb_at) ? 8'h0F : 8'hFF;
      bus.wlast  = (k == last_at);
      n = 0;
      while (!bus.wready && n < 50) begin
        tick();
        n++;
      end
      if (bus.wready) accepted++;
      else begin
        vectors++;
        miscompares++;
        $display("FAIL w_timeout beat=%0d wready=%0b required=1", k, bus.wready);
      end
      tick();
      bus.wvalid = 1'b0;
      bus.wlast  = 1'b0;
      if (bubbles && (k % 2 == 0)) tick();
    end
  endtask

  task automatic test_reset;
    idle_inputs();
    reset = 1'b1;
    repeat (3) tick();
    vectors++;
    if ({bus.awready, bus.wready, bus.bvalid, bus.req_valid} !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_handshakes got=%b required=0000",
               {bus.awready, bus.wready, bus.bvalid, bus.req_valid});
    end
    vectors++;
    if ({bus.bresp, bus.bid, bus.req_id, bus.req_addr} !== '0) begin
      miscompares++;
      $display("FAIL reset_fields bresp=%0h bid=%0h req_id=%0h req_addr=%0h required=0",
               bus.bresp, bus.bid, bus.req_id, bus.req_addr);
    end
    vectors++;
    if (bus.req_data !== '0) begin
      miscompares++;
      $display("FAIL reset_req_data got_nonzero required=0");
    end
    reset = 1'b0;
    vectors++;
    if (bus.awready !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_release_awready got=%0b required=0", bus.awready);
    end
    tick();
    vectors++;
    if (bus.awready !== 1'b1) begin
      miscompares++;
      $display("FAIL awready_after_reset got=%0b required=1", bus.awready);
    end
  endtask

  task automatic test_aligned;
    int acc;
    bus.req_ready = 1'b1;
    send_aw(4'd3, 32'h4000_0040, 8'd7, 3'd3);
    vectors++;
    if ({bus.awready, bus.wready} !== 2'b01) begin
      miscompares++;
      $display("FAIL aligned_data_state awready,wready=%b required=01", {bus.awready, bus.wready});
    end
    send_beats(64'd1, 8, 7, -1, 1'b0, acc);
    vectors++;
    if (acc !== 8 || bus.wready !== 1'b0) begin
      miscompares++;
      $display("FAIL aligned_beats accepted=%0d wready=%0b required=8,0", acc, bus.wready);
    end
    vectors++;
    if (bus.req_valid !== 1'b1 || bus.req_addr !== 32'h4000_0040 || bus.req_id !== 4'd3) begin
      miscompares++;
      $display("FAIL aligned_req valid=%0b addr=%h id=%0d required=1,40000040,3",
               bus.req_valid, bus.req_addr, bus.req_id);
    end
    for (int k = 0; k < 8; k++) begin
      vectors++;
      if (bus.req_data[k*64 +: 64] !== 64'(k + 1)) begin
        miscompares++;
        $display("FAIL aligned_slot%0d got=%h required=%h", k, bus.req_data[k*64 +: 64], 64'(k + 1));
      end
    end
    tick();
    vectors++;
    if ({bus.req_valid, bus.bvalid} !== 2'b01 || bus.bid !== 4'd3 || bus.bresp !== RESP_OKAY) begin
      miscompares++;
      $display("FAIL aligned_b req_valid=%0b bvalid=%0b bid=%0d bresp=%0d required=0,1,3,0",
               bus.req_valid, bus.bvalid, bus.bid, bus.bresp);
    end
    bus.req_ready = 1'b0;
    bus.bready = 1'b1;
    tick();
    bus.bready = 1'b0;
    vectors++;
    if ({bus.bvalid, bus.awready} !== 2'b01) begin
      miscompares++;
      $display("FAIL aligned_after_b bvalid,awready=%b required=01", {bus.bvalid, bus.awready});
    end
  endtask

  task automatic test_backpressure;
    int acc;
    int hs;
    logic [511:0] line;
    for (int k = 0; k < 8; k++) line[k*64 +: 64] = 64'hA0 + 64'(k);
    bus.req_ready = 1'b0;
    send_aw(4'd5, 32'h0000_1000, 8'd7, 3'd3);
    send_beats(64'hA0, 8, 7, -1, 1'b0, acc);
    for (int c = 0; c < 20; c++) begin
      vectors++;
      if (bus.req_valid !== 1'b1 || bus.req_addr !== 32'h0000_1000 || bus.req_id !== 4'd5 ||
          bus.req_data !== line || bus.bvalid !== 1'b0) begin
        miscompares++;
        $display("FAIL backpressure_hold cycle=%0d valid=%0b addr=%h id=%0d bvalid=%0b data_ok=%0b required=1,00001000,5,0,1",
                 c, bus.req_valid, bus.req_addr, bus.req_id, bus.bvalid, bus.req_data === line);
      end
      tick();
    end
    bus.req_ready = 1'b1;
    hs = 0;
    repeat (4) begin
      if (bus.req_valid) hs++;
      tick();
    end
    bus.req_ready = 1'b0;
    vectors++;
    if (hs !== 1 || bus.bvalid !== 1'b1 || bus.bid !== 4'd5 || bus.bresp !== RESP_OKAY) begin
      miscompares++;
      $display("FAIL backpressure_release handshakes=%0d bvalid=%0b bid=%0d bresp=%0d required=1,1,5,0",
               hs, bus.bvalid, bus.bid, bus.bresp);
    end
    bus.bready = 1'b1;
    tick();
    bus.bready = 1'b0;
  endtask

  task automatic bad_burst(input string name, input logic [3:0] id, input logic [31:0] addr,
                           input int last_at, input int bad_strb_at);
    int acc;
    int seen0;
    bus.req_ready = 1'b1;
    seen0 = req_seen;
    send_aw(id, addr, 8'd7, 3'd3);
    send_beats(64'h55, 8, last_at, bad_strb_at, 1'b0, acc);
    vectors++;
    if (acc !== 8 || bus.wready !== 1'b0) begin
      miscompares++;
      $display("FAIL %s_beats accepted=%0d wready=%0b required=8,0", name, acc, bus.wready);
    end
    vectors++;
    if (bus.bvalid !== 1'b1 || bus.bresp !== RESP_SLVERR || bus.bid !== id || bus.req_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL %s_b bvalid=%0b bresp=%0d bid=%0d req_valid=%0b required=1,2,%0d,0",
               name, bus.bvalid, bus.bresp, bus.bid, bus.req_valid, id);
    end
    bus.bready = 1'b1;
    tick();
    bus.bready = 1'b0;
    bus.req_ready = 1'b0;
    vectors++;
    if (req_seen - seen0 !== 0) begin
      miscompares++;
      $display("FAIL %s_no_req req_valid_cycles=%0d required=0", name, req_seen - seen0);
    end
  endtask

  task automatic test_malformed;
    int acc;
    bad_burst("misaligned", 4'd6, 32'h4000_0008, 7, -1);
    bad_burst("early_wlast", 4'd7, 32'h4000_0080, 3, -1);
    bad_burst("bad_strb", 4'd8, 32'h4000_00C0, 7, 5);
    bus.req_ready = 1'b1;
    send_aw(4'd9, 32'h4000_0200, 8'd7, 3'd3);
    send_beats(64'h900, 8, 7, -1, 1'b0, acc);
    vectors++;
    if (bus.req_valid !== 1'b1 || bus.req_data[7*64 +: 64] !== 64'h907) begin
      miscompares++;
      $display("FAIL recover_req valid=%0b slot7=%h required=1,907", bus.req_valid, bus.req_data[7*64 +: 64]);
    end
    tick();
    vectors++;
    if (bus.bvalid !== 1'b1 || bus.bresp !== RESP_OKAY || bus.bid !== 4'd9) begin
      miscompares++;
      $display("FAIL recover_b bvalid=%0b bresp=%0d bid=%0d required=1,0,9", bus.bvalid, bus.bresp, bus.bid);
    end
    bus.req_ready = 1'b0;
    bus.bready = 1'b1;
    tick();
    bus.bready = 1'b0;
  endtask

  task automatic test_bubbles;
    int acc;
    logic [511:0] line;
    for (int k = 0; k < 8; k++) line[k*64 +: 64] = 64'h100 + 64'(k);
    bus.req_ready = 1'b1;
    send_aw(4'd10, 32'h4000_0080, 8'd7, 3'd3);
    send_beats(64'h100, 8, 7, -1, 1'b1, acc);
    vectors++;
    if (acc !== 8 || bus.req_valid !== 1'b1 || bus.req_data !== line) begin
      miscompares++;
      $display("FAIL bubbles_data accepted=%0d req_valid=%0b data_ok=%0b required=8,1,1",
               acc, bus.req_valid, bus.req_data === line);
    end
    tick();
    bus.req_ready = 1'b0;
    for (int c = 0; c < 10; c++) begin
      vectors++;
      if (bus.awready !== 1'b0 || bus.bvalid !== 1'b1) begin
        miscompares++;
        $display("FAIL bready_delay cycle=%0d awready=%0b bvalid=%0b required=0,1", c, bus.awready, bus.bvalid);
      end
      tick();
    end
    bus.bready = 1'b1;
    tick();
    bus.bready = 1'b0;
    vectors++;
    if ({bus.bvalid, bus.awready} !== 2'b01) begin
      miscompares++;
      $display("FAIL bubbles_after_b bvalid,awready=%b required=01", {bus.bvalid, bus.awready});
    end
  endtask

  task automatic test_reset_mid_burst;
    int acc;
    int bseen;
    bus.req_ready = 1'b1;
    send_aw(4'd11, 32'h4000_0100, 8'd7, 3'd3);
    send_beats(64'h200, 4, 7, -1, 1'b0, acc);
    reset = 1'b1;
    tick();
    vectors++;
    if ({bus.awready, bus.wready, bus.bvalid, bus.req_valid} !== 4'b0000 ||
        {bus.bresp, bus.bid, bus.req_id, bus.req_addr} !== '0 || bus.req_data !== '0) begin
      miscompares++;
      $display("FAIL midreset_outputs aw=%0b w=%0b b=%0b req=%0b bid=%0d req_addr=%h required=all0",
               bus.awready, bus.wready, bus.bvalid, bus.req_valid, bus.bid, bus.req_addr);
    end
    reset = 1'b0;
    bus.bready = 1'b1;
    bseen = 0;
    repeat (6) begin
      tick();
      if (bus.bvalid) bseen++;
    end
    bus.bready = 1'b0;
    vectors++;
    if (bseen !== 0) begin
      miscompares++;
      $display("FAIL midreset_no_b bvalid_cycles=%0d required=0", bseen);
    end
    send_aw(4'd12, 32'h4000_0140, 8'd7, 3'd3);
    send_beats(64'h300, 8, 7, -1, 1'b0, acc);
    vectors++;
    if (bus.req_valid !== 1'b1 || bus.req_addr !== 32'h4000_0140 || bus.req_data[3*64 +: 64] !== 64'h303) begin
      miscompares++;
      $display("FAIL fresh_req valid=%0b addr=%h slot3=%h required=1,40000140,303",
               bus.req_valid, bus.req_addr, bus.req_data[3*64 +: 64]);
    end
    tick();
    vectors++;
    if (bus.bvalid !== 1'b1 || bus.bresp !== RESP_OKAY || bus.bid !== 4'd12) begin
      miscompares++;
      $display("FAIL fresh_b bvalid=%0b bresp=%0d bid=%0d required=1,0,12", bus.bvalid, bus.bresp, bus.bid);
    end
    bus.req_ready = 1'b0;
    bus.bready = 1'b1;
    tick();
    bus.bready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_aligned();
    test_backpressure();
    test_malformed();
    test_bubbles();
    test_reset_mid_burst();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not complete in time");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/axi4_wline_gather.md
# axi4_wline_gather

AXI4 write-side ingress stage placed directly upstream of the Frontend request port. It accepts one AXI4 write burst at a time (AW + 8 W beats of 64 bits), assembles the beats into a 512-bit cacheline write request, and hands it to the Frontend over a valid/ready port. It returns the AXI4 B response once the Frontend accepts the line, or immediately with SLVERR for malformed bursts.

## Interface
- IDBITS, 4, AXI ID width
- DATABITS, 64, AXI data width; BEATS = 512/DATABITS = 8
- ADDRBITS, 32, address width
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- awvalid/awready  in/out  1  AW handshake
- awid  in  IDBITS  write ID
- awaddr  in  ADDRBITS  byte address
- awlen  in  8  burst length minus 1
- awsize  in  3  log2 bytes per beat
- awburst  in  2  burst type, INCR (2'b01) or FIXED (2'b00)
- wvalid/wready  in/out  1  W handshake
- wdata  in  DATABITS  beat data
- wstrb  in  DATABITS/8  byte strobes
- wlast  in  1  last beat flag
- bvalid/bready  out/in  1  B handshake
- bid  out  IDBITS  response ID
- bresp  out  2  OKAY 2'b00 or SLVERR 2'b10
- req_valid/req_ready  out/in  1  line request to the Frontend
- req_addr  out  ADDRBITS  line address, awaddr with bits [5:0] cleared
- req_id  out  IDBITS  captured awid
- req_data  out  512  assembled line; beat k occupies bits [k*64 +: 64]

## Operation
- States: IDLE, DATA, REQ, RESP.
- IDLE: awready=1. On an AW handshake, capture awid and awaddr. Set err if any of: awlen != 7; awsize != 3; awaddr[5:0] != 0. Clear the beat counter. Go to DATA.
- DATA: wready=1. On each W handshake, write wdata into line slot cnt and increment cnt (3 bits).
  - Set err if wstrb is not all-ones.
  - Set err if wlast != (cnt==7).
  - On the beat where cnt==7: go to RESP if err, otherwise go to REQ.
  - An early wlast does not end the burst. Exactly 8 beats are always consumed.
- REQ: req_valid=1. req_addr, req_id and req_data stay stable until req_ready. On the handshake, go to RESP with bresp=OKAY.
- RESP: bvalid=1, bid=captured id, bresp = err ? SLVERR : OKAY. On bready, clear err and return to IDLE.
- Only one burst is in flight. awready=0 and wready=0 in every state except the one named above.
- awburst is ignored. Any value is accepted because the line is always filled sequentially.

## Timing
- Reset values: awready=0, wready=0, bvalid=0, req_valid=0, bresp=0, bid=0, req_id=0, req_addr=0, req_data=0, state=IDLE, cnt=0, err=0. awready rises the first cycle after reset deasserts.
- All outputs are registered or decoded from state only. There are no combinational paths from inputs to outputs.
- AW handshake at cycle N. The earliest first W handshake is N+1. The earliest 8th beat is N+8. req_valid is high at N+9. bvalid is high the cycle after the req handshake. The earliest next awready is the cycle after the B handshake.
- W beats may carry bubbles (wvalid low). cnt advances only on a handshake.
- req_ready or bready may be held high in advance. The handshake then completes in the first cycle of the state.
- wvalid asserted during IDLE is ignored. wready=0, so the beat stays pending for the master.
- Reset mid-burst: all state is discarded and no B is issued. A partially sent burst must be re-driven by the master after reset.

## Structure
- Shared package mpe_axi_pkg holds:
  - LINEBITS=512
  - RESP_OKAY=2'b00, RESP_SLVERR=2'b10
  - AXI_SIZE_64=3'd3
  - the wg_state_e enum {IDLE, DATA, REQ, RESP}
- Single module with no sub-modules. The line buffer is a 512-bit register written by part-select.
- Target size: about 150–200 lines.

## Test plan
- Aligned burst: awaddr=0x40000040, id=3, beats wdata=k+1 (k=0..7), req_ready=1 → req_addr=0x40000040, req_data[k*64+:64]=k+1, then bid=3, bresp=OKAY.
- Backpressure: hold req_ready=0 for 20 cycles → req_valid stays high and all req_* fields stay stable. Release → exactly one handshake, then B.
- Misaligned awaddr=0x40000008 → all 8 beats consumed, req_valid never rises, bresp=SLVERR.
- wlast asserted on beat 3, or wstrb=0x0F on beat 5 → 8 beats still consumed, no request, bresp=SLVERR. The next well-formed burst gets OKAY.
- W bubbles (wvalid toggling) and bready delayed 10 cycles → data correct, awready stays 0 until the B handshake.
- reset asserted after beat 4 → all outputs at reset values next cycle, no B. A fresh burst afterwards completes with OKAY.
